// File: rtl/lsu_pkg.sv
// lsu_pkg: shared load/store unit encodings and load data extension helpers
package lsu_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Select the addressed lanes of an aligned doubleword and extend to XLEN.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] data,
        input logic [2:0]      offset,
        input logic [1:0]      size,
        input logic            uns
    );
        logic [XLEN-1:0] sh;
        logic            sx;
        sh = data >> {offset, 3'b000};
        sx = !uns;
        return (size == SZ_B) ? {{56{sx & sh[7]}},  sh[7:0]}  :
               (size == SZ_H) ? {{48{sx & sh[15]}}, sh[15:0]} :
               (size == SZ_W) ? {{32{sx & sh[31]}}, sh[31:0]} :
                                sh;
    endfunction

    // An access is misaligned when any offset bit below its natural size is set.
    function automatic logic misaligned(
        input logic [2:0] offset,
        input logic [1:0] size
    );
        logic [2:0] mask;
        mask = (size == SZ_B) ? 3'd0 :
               (size == SZ_H) ? 3'd1 :
               (size == SZ_W) ? 3'd3 : 3'd7;
        return |(offset & mask);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: registered-storage FIFO with occupancy count and sync active-low reset
module wb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [AW:0]  count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;

    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer and occupancy state; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/load_wb_queue.sv
// load_wb_queue: aligns/extends dcache load responses and queues them for register writeback
module load_wb_queue
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [XLEN-1:0]       mem_resp_data,
    input  logic [2:0]            mem_resp_offset,
    input  logic [1:0]            mem_resp_size,
    input  logic                  mem_resp_unsigned,
    input  logic [REG_AW-1:0]     mem_resp_rd,
    output logic                  dcache_ack_valid,
    output logic [XLEN-1:0]       dcache_ack_data,
    output logic [REG_AW-1:0]     dcache_ack_rd,
    input  logic                  dcache_ack_retry,
    output logic                  misalign_err,
    output logic [REG_AW-1:0]     misalign_rd,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int EW = REG_AW + XLEN;

    logic accept, mis, push, pop, full, empty;
    logic [EW-1:0] head;
    logic err_q, err_d;
    logic [REG_AW-1:0] erd_q, erd_d;

    assign mem_resp_ready = reset && !full;
    assign accept = mem_resp_valid && mem_resp_ready;
    assign mis    = misaligned(mem_resp_offset, mem_resp_size);
    assign push   = accept && !mis && |mem_resp_rd;

    assign dcache_ack_valid = reset && !empty;
    assign pop              = dcache_ack_valid && !dcache_ack_retry;
    assign dcache_ack_rd    = dcache_ack_valid ? head[EW-1:XLEN] : '0;
    assign dcache_ack_data  = dcache_ack_valid ? head[XLEN-1:0] : '0;

    assign misalign_err = reset && err_q;
    assign misalign_rd  = reset ? erd_q : '0;

    // Extension happens before the write so the head is ready the next cycle.
    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  ({mem_resp_rd, load_extend(mem_resp_data, mem_resp_offset, mem_resp_size, mem_resp_unsigned)}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (q_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // A misaligned accept raises a single-cycle error carrying its rd.
    always_comb begin
        err_d = accept && mis;
        erd_d = err_d ? mem_resp_rd : '0;
    end

    // Error pulse register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
            erd_q <= '0;
        end else begin
            err_q <= err_d;
            erd_q <= erd_d;
        end
    end

endmodule
